// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array sequencer: the FSM state encoding
// and the elaboration-time helpers that turn array geometry into phase lengths.
// No ports; imported by systolic_sequencer.
// -----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_PRELOAD = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_COLLECT = 3'd4,
        ST_UNLOAD  = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_t;

    // Cycles spent streaming inputs through a row of W PEs.
    function automatic int unsigned compute_len(input int unsigned dsp_delay,
                                                input int unsigned width);
        return dsp_delay * width;
    endfunction

    // Cycles for the last partial sum to ripple down H rows and drain.
    function automatic int unsigned collect_len(input int unsigned dsp_delay,
                                                input int unsigned height);
        return dsp_delay * (height - 1) + height;
    endfunction

    function automatic int unsigned max_phase_len(input int unsigned height,
                                                  input int unsigned width,
                                                  input int unsigned dsp_delay);
        int unsigned a;
        int unsigned b;
        a = compute_len(dsp_delay, width);
        b = collect_len(dsp_delay, height);
        if (height > a && height > b)
            return height;
        return (a > b) ? a : b;
    endfunction

    // Bits needed for a counter that can hold max_val itself.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/seq_phase_cnt.sv
// -----------------------------------------------------------------------------
// seq_phase_cnt
// Down-counter timing one sequencer phase. Loaded with (phase length - 1) on
// phase entry, counts to zero and holds there; tc flags the last cycle.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset
//   load     - load load_val this cycle (takes priority over counting)
//   load_val - terminal-count start value
//   tc       - count has reached zero
// -----------------------------------------------------------------------------
module seq_phase_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/systolic_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_sequencer
// Job sequencer for a weight-stationary systolic array. For each tile it steps
// through weight load, preload, compute, collect and unload phases, driving the
// buffer enables for the top level.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | waiting for start
//   LOAD_W     | weight buffer filled from host, H cycles
//   PRELOAD    | weights written into PEs, input buffer filled, H cycles
//   COMPUTE    | inputs streamed across the array, DSP_DELAY*W cycles
//   COLLECT    | partial sums drained into output buffer
//   UNLOAD     | output buffer read out to host, H cycles
//   DONE       | one-cycle done pulse
//
// Ports:
//   clk, rst            - clock (rising) and synchronous active-low reset
//   start, num_tiles,
//   reuse_weight        - job request, captured in IDLE
//   abort               - cancel current job, back to IDLE without done
//   *_en                - buffer / PE enables
//   row_idx, tile_idx   - host addressing
//   busy, done          - status
// -----------------------------------------------------------------------------
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int unsigned ARRAYHEIGHT = 16,
    parameter int unsigned ARRAYWIDTH  = 16,
    parameter int unsigned DSP_DELAY   = 1,
    parameter int unsigned TILE_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [TILE_W-1:0]              num_tiles,
    input  logic                           reuse_weight,
    input  logic                           abort,
    output logic                           weight_buffer_load_en,
    output logic                           weight_buffer_out_en,
    output logic                           write_weight_en,
    output logic                           input_buffer_load_en,
    output logic                           input_buffer_out_en,
    output logic                           output_buffer_load_en,
    output logic                           output_buffer_out_en,
    output logic [$clog2(ARRAYHEIGHT)-1:0] row_idx,
    output logic [TILE_W-1:0]              tile_idx,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned ROW_W       = $clog2(ARRAYHEIGHT);
    localparam int unsigned LEN_ROWS    = ARRAYHEIGHT;
    localparam int unsigned LEN_COMPUTE = compute_len(DSP_DELAY, ARRAYWIDTH);
    localparam int unsigned LEN_COLLECT = collect_len(DSP_DELAY, ARRAYHEIGHT);
    localparam int unsigned MAX_LEN     = max_phase_len(ARRAYHEIGHT, ARRAYWIDTH, DSP_DELAY);
    localparam int unsigned CNT_W       = cnt_width(MAX_LEN);

    localparam logic [CNT_W-1:0] TC_ROWS    = CNT_W'(LEN_ROWS - 1);
    localparam logic [CNT_W-1:0] TC_COMPUTE = CNT_W'(LEN_COMPUTE - 1);
    localparam logic [CNT_W-1:0] TC_COLLECT = CNT_W'(LEN_COLLECT - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [TILE_W-1:0] tiles_cap;
    logic [TILE_W-1:0] tiles_cap_next;
    logic              reuse_cap;
    logic              reuse_next;
    logic [TILE_W-1:0] tile_next;
    logic [ROW_W-1:0]  row_next;
    logic              w_skip_next;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              phase_tc;
    logic              last_tile;

    seq_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .tc       (phase_tc)
    );

    assign last_tile = (tile_idx == tiles_cap - TILE_W'(1));

    always_comb begin
        state_next     = state;
        tiles_cap_next = tiles_cap;
        reuse_next     = reuse_cap;
        tile_next      = tile_idx;
        row_next       = '0;
        cnt_load       = 1'b0;
        cnt_load_val   = '0;

        if (state != ST_IDLE && abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tiles_cap_next = num_tiles;
                        reuse_next     = reuse_weight;
                        tile_next      = '0;
                        state_next     = (num_tiles == '0) ? ST_DONE : ST_LOAD_W;
                    end
                end
                ST_LOAD_W:  if (phase_tc) state_next = ST_PRELOAD;
                ST_PRELOAD: if (phase_tc) state_next = ST_COMPUTE;
                ST_COMPUTE: if (phase_tc) state_next = ST_COLLECT;
                ST_COLLECT: if (phase_tc) state_next = ST_UNLOAD;
                ST_UNLOAD: begin
                    if (phase_tc) begin
                        if (last_tile) begin
                            state_next = ST_DONE;
                        end else begin
                            tile_next  = tile_idx + TILE_W'(1);
                            state_next = reuse_cap ? ST_PRELOAD : ST_LOAD_W;
                        end
                    end
                end
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end

        // Host-visible tile index reads zero whenever the sequencer is idle.
        if (state_next == ST_IDLE)
            tile_next = '0;

        // Every phase change reloads the timer; within a row-addressed phase
        // the row offset advances once per cycle.
        if (state_next != state) begin
            cnt_load = 1'b1;
            case (state_next)
                ST_LOAD_W, ST_PRELOAD, ST_UNLOAD: cnt_load_val = TC_ROWS;
                ST_COMPUTE:                       cnt_load_val = TC_COMPUTE;
                ST_COLLECT:                       cnt_load_val = TC_COLLECT;
                default:                          cnt_load_val = '0;
            endcase
        end else if (state inside {ST_LOAD_W, ST_PRELOAD, ST_UNLOAD}) begin
            row_next = row_idx + ROW_W'(1);
        end
    end

    // Weights already resident in the PEs from tile 0 are kept.
    assign w_skip_next = reuse_next && (tile_next != '0);

    // Outputs are registered from the next-state decode so they line up with
    // the state register without any combinational path to the pins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state                 <= ST_IDLE;
            tiles_cap             <= '0;
            reuse_cap             <= 1'b0;
            tile_idx              <= '0;
            row_idx               <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            weight_buffer_load_en <= 1'b0;
            weight_buffer_out_en  <= 1'b0;
            write_weight_en       <= 1'b0;
            input_buffer_load_en  <= 1'b0;
            input_buffer_out_en   <= 1'b0;
            output_buffer_load_en <= 1'b0;
            output_buffer_out_en  <= 1'b0;
        end else begin
            state                 <= state_next;
            tiles_cap             <= tiles_cap_next;
            reuse_cap             <= reuse_next;
            tile_idx              <= tile_next;
            row_idx               <= row_next;
            busy                  <= (state_next != ST_IDLE);
            done                  <= (state_next == ST_DONE);
            weight_buffer_load_en <= (state_next == ST_LOAD_W);
            weight_buffer_out_en  <= (state_next == ST_PRELOAD) && !w_skip_next;
            write_weight_en       <= (state_next == ST_PRELOAD) && !w_skip_next;
            input_buffer_load_en  <= (state_next == ST_PRELOAD);
            input_buffer_out_en   <= (state_next == ST_COMPUTE) || (state_next == ST_COLLECT);
            output_buffer_load_en <= (state_next == ST_COLLECT);
            output_buffer_out_en  <= (state_next == ST_UNLOAD);
        end
    end

endmodule
